// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned       INST_W           = 16;
    localparam int unsigned       PC_W             = 16;
    localparam logic [PC_W-1:0]   PC_STEP          = 16'd2;
    localparam logic [PC_W-1:0]   RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH need not be a power of 2.
module ifu_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;
    logic             empty;
    logic             full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (32'(p) == DEPTH - 1)
            return '0;
        else
            return p + PW'(1);
    endfunction

    always_comb begin
        empty     = (count == '0);
        full      = (32'(count) == DEPTH);
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        head_data = mem[rd_ptr];
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues PC-stepped fetches, buffers words with their PC, handles redirects.
// Optional IFU_BYPASS_EN: forward a response straight to decode when the FIFO is empty.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     MAX_OUT  = 2,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [PC_W-1:0]   mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [PC_W-1:0]   inst_pc
);

    localparam int unsigned     FCW     = $clog2(DEPTH + 1);
    localparam int unsigned     OCW     = $clog2(MAX_OUT + 1);
    localparam logic [PC_W-1:0] PC_MASK = ~PC_W'(1);

    ifu_state_e               state_q, state_d;
    logic [PC_W-1:0]          fetch_pc_q;
    logic [OCW-1:0]           stale_q, stale_d;
    logic [OCW-1:0]           outstanding;
    logic [OCW-1:0]           out_after;
    logic [FCW-1:0]           fifo_count;
    logic                     fifo_empty;
    logic [PC_W+INST_W-1:0]   fifo_head;
    logic [PC_W-1:0]          tag_pc;
    logic                     req_fire;
    logic                     keep_rsp;
    logic                     fifo_push;
    logic                     fifo_pop;

    // The tag FIFO holds one PC per in-flight request, so its count is the outstanding count.
    ifu_fifo #(
        .WIDTH (PC_W),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (mem_rsp_valid),
        .head_data (tag_pc),
        .count     (outstanding)
    );

    ifu_fifo #(
        .WIDTH (PC_W + INST_W),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data ({tag_pc, mem_rsp_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        fifo_empty    = (fifo_count == '0);
        mem_req_addr  = fetch_pc_q;
        mem_req_valid = rst_n && (state_q == RUN)
                        && (32'(outstanding) < MAX_OUT)
                        && (32'(fifo_count) + 32'(outstanding) < DEPTH);
        req_fire      = mem_req_valid && mem_req_ready;
        out_after     = outstanding + OCW'(req_fire) - OCW'(mem_rsp_valid);
        keep_rsp      = mem_rsp_valid && (stale_q == '0) && !redirect_valid;
        fifo_pop      = inst_ready && (state_q == RUN) && !fifo_empty;
`ifdef IFU_BYPASS_EN
        if (keep_rsp && fifo_empty && (state_q == RUN)) begin
            inst_valid = 1'b1;
            inst_pc    = tag_pc;
            inst_data  = mem_rsp_data;
            fifo_push  = !inst_ready;
        end else begin
            inst_valid = (state_q == RUN) && !fifo_empty;
            inst_pc    = fifo_head[PC_W+INST_W-1:INST_W];
            inst_data  = fifo_head[INST_W-1:0];
            fifo_push  = keep_rsp;
        end
`else
        inst_valid = (state_q == RUN) && !fifo_empty;
        inst_pc    = fifo_head[PC_W+INST_W-1:INST_W];
        inst_data  = fifo_head[INST_W-1:0];
        fifo_push  = keep_rsp;
`endif
    end

    // Stale covers everything still in flight once this cycle's handshake and response settle.
    always_comb begin
        state_d = state_q;
        stale_d = stale_q;
        if (redirect_valid) begin
            stale_d = out_after;
            state_d = (out_after != '0) ? DRAIN : RUN;
        end else if (mem_rsp_valid && (stale_q != '0)) begin
            stale_d = stale_q - OCW'(1);
            if ((state_q == DRAIN) && (stale_q == OCW'(1)))
                state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            stale_q    <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            stale_q <= stale_d;
            if (redirect_valid)
                fetch_pc_q <= redirect_pc & PC_MASK;
            else if (req_fire)
                fetch_pc_q <= fetch_pc_q + PC_STEP;
        end
    end

    rsp_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_OUT = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        mem_req_valid, mem_req_ready;
    logic [15:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [15:0] mem_rsp_data;
    logic        inst_valid, inst_ready;
    logic [15:0] inst_data, inst_pc;

    logic        w_req_valid;
    logic [15:0] w_req_addr;
    logic        w_rsp_valid;
    logic [15:0] w_rsp_data;
    logic        w_inst_valid;
    logic [15:0] w_inst_data, w_inst_pc;

    instr_fetch_unit #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    instr_fetch_unit #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(16'hFFFC)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(1'b0), .redirect_pc(16'h0000),
        .mem_req_valid(w_req_valid), .mem_req_ready(1'b1), .mem_req_addr(w_req_addr),
        .mem_rsp_valid(w_rsp_valid), .mem_rsp_data(w_rsp_data),
        .inst_valid(w_inst_valid), .inst_ready(1'b1),
        .inst_data(w_inst_data), .inst_pc(w_inst_pc)
    );

    typedef struct { logic [15:0] addr; bit stale; } req_t;
    typedef struct { logic [15:0] pc; logic [15:0] data; } ins_t;

    req_t        pend[$];
    ins_t        instq[$];
    logic [15:0] m_pc;
    bit          m_known = 1'b0;
    bit          m_fresh;
    logic [15:0] w_pend[$];
    logic [15:0] w_exp;
    int          w_seen = 0;

    int          errors = 0;
    int          checks = 0;
    int          n_req  = 0;
    int          n_inst = 0;
    int          rsp_mode;
    int unsigned rsp_pct;

    function automatic bit draining();
        foreach (pend[i]) if (pend[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: present memory response, check outputs, advance model at the edge.
    task automatic step();
        bit          exp_req, exp_iv, req_f, inst_f, rsp_now, redir, rst_now, w_rsp_now, w_req_f;
        logic [15:0] tgt, w_addr;
        req_t        r;
        if (rst_n && m_known && pend.size() > 0 &&
            (rsp_mode == 1 || (rsp_mode == 2 && $urandom_range(0, 99) < rsp_pct))) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = pend[0].addr ^ 16'hA5A5;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 16'($urandom);
        end
        if (rst_n && m_known && w_pend.size() > 0) begin
            w_rsp_valid = 1'b1;
            w_rsp_data  = w_pend[0] ^ 16'hA5A5;
        end else begin
            w_rsp_valid = 1'b0;
            w_rsp_data  = 16'h0000;
        end
        #1;
        exp_req = 1'b0;
        exp_iv  = 1'b0;
        if (m_known) begin
            exp_req = rst_n && !draining() && pend.size() < MAX_OUT
                      && instq.size() + pend.size() < DEPTH;
            exp_iv  = !draining() && instq.size() > 0;
            chk("req_valid", 32'(mem_req_valid), 32'(exp_req));
            chk("req_addr", 32'(mem_req_addr), 32'(m_pc));
            chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
            if (exp_iv) begin
                chk("inst_pc", 32'(inst_pc), 32'(instq[0].pc));
                chk("inst_data", 32'(inst_data), 32'(instq[0].data));
            end else if (m_fresh) begin
                chk("idle_pc", 32'(inst_pc), 32'h0);
                chk("idle_data", 32'(inst_data), 32'h0);
            end
            if (w_inst_valid) begin
                chk("wrap_pc", 32'(w_inst_pc), 32'(w_exp));
                chk("wrap_data", 32'(w_inst_data), 32'(w_exp ^ 16'hA5A5));
                w_exp = w_exp + 16'd2;
                w_seen++;
            end
        end
        req_f     = exp_req && mem_req_ready;
        inst_f    = exp_iv && inst_ready;
        rsp_now   = mem_rsp_valid;
        redir     = redirect_valid;
        tgt       = redirect_pc;
        rst_now   = rst_n;
        w_rsp_now = w_rsp_valid;
        w_req_f   = w_req_valid;
        w_addr    = w_req_addr;
        n_req    += int'(req_f);
        n_inst   += int'(inst_f);
        @(posedge clk);
        if (!rst_now) begin
            pend.delete();
            instq.delete();
            w_pend.delete();
            m_pc    = 16'h0000;
            w_exp   = 16'hFFFC;
            m_known = 1'b1;
            m_fresh = 1'b1;
        end else if (m_known) begin
            if (inst_f) void'(instq.pop_front());
            if (rsp_now) begin
                r = pend.pop_front();
                if (!r.stale) begin
                    instq.push_back('{r.addr, r.addr ^ 16'hA5A5});
                    m_fresh = 1'b0;
                end
            end
            if (req_f) begin
                pend.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 16'd2;
            end
            if (redir) begin
                instq.delete();
                foreach (pend[i]) pend[i].stale = 1'b1;
                m_pc = tgt & 16'hFFFE;
            end
            if (w_rsp_now) void'(w_pend.pop_front());
            if (w_req_f) w_pend.push_back(w_addr);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        mem_req_ready  = 1'b1;
        inst_ready     = 1'b1;
        rsp_mode       = 1;
        rsp_pct        = 50;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 16'h0000;
        w_rsp_valid    = 1'b0;
        w_rsp_data     = 16'h0000;

        // Reset, then first request
        step();
        step();
        chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("first_req_valid", 32'(mem_req_valid), 32'h1);
        chk("first_req_addr", 32'(mem_req_addr), 32'h0000);

        // Streaming at one instruction per cycle
        repeat (4) step();
        base = n_inst;
        repeat (8) step();
        chk("stream_rate", 32'(n_inst - base), 32'd8);

        // Decode backpressure fills exactly DEPTH entries
        do_reset();
        inst_ready = 1'b0;
        base = n_req;
        repeat (10) step();
        chk("bp_issued", 32'(n_req - base), 32'(DEPTH));
        chk("bp_stall", 32'(mem_req_valid), 32'h0);
        chk("bp_addr", 32'(mem_req_addr), 32'h0008);
        inst_ready = 1'b1;
        base = n_inst;
        repeat (4) step();
        chk("bp_drain", 32'(n_inst - base), 32'd4);
        repeat (4) step();

        // Redirect with two requests outstanding
        do_reset();
        rsp_mode = 0;
        base = n_req;
        step();
        step();
        chk("rd_outstanding", 32'(n_req - base), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0041;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("rd_drain_req", 32'(mem_req_valid), 32'h0);
        chk("rd_drain_inst", 32'(inst_valid), 32'h0);
        rsp_mode = 1;
        for (int k = 0; k < 12 && !inst_valid; k++) step();
        chk("rd_found", 32'(inst_valid), 32'h1);
        chk("rd_first_pc", 32'(inst_pc), 32'h0040);

        // Redirect coinciding with a response and a request handshake
        do_reset();
        rsp_mode = 1;
        repeat (6) step();
        chk("sim_req", 32'(mem_req_valid), 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        step();
        redirect_valid = 1'b0;
        base = n_inst;
        for (int k = 0; k < 10; k++) begin
            if (inst_valid)
                chk("sim_new_pc", 32'(inst_pc >= 16'h0100 && inst_pc < 16'h0140), 32'h1);
            step();
        end
        chk("sim_progress", 32'(n_inst - base > 0), 32'h1);

        // Randomized traffic with redirects and occasional resets
        do_reset();
        rsp_mode = 2;
        for (int k = 0; k < 800; k++) begin
            rsp_pct        = $urandom_range(20, 90);
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 16'($urandom);
            rst_n          = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        chk("wrap_seen", 32'(w_seen >= 4), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
